// File: rtl/display_scan_ctrl.sv
// Digit scan controller for a 4-digit multiplexed display.
// Steps a 2-bit digit select at a prescaled rate and presents the matching
// nibble of the active display word. It blanks the decoder during a
// dead-time window at the start of each slot, and also blanks leading-zero
// digits when that is enabled. A new display word is parked in a pending
// register and becomes active only at a frame boundary, or at once when
// the scan is idle.
module display_scan_ctrl #(
  parameter int PRESCALE = 50000,
  parameter int DEADTIME = 8
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_en,
  input  logic        i_load,
  input  logic [15:0] i_value,
  input  logic        i_blank_lz,
  output logic [1:0]  o_sel,
  output logic [3:0]  o_nibble,
  output logic        o_digit_off,
  output logic        o_load_ack,
  output logic        o_frame_done
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] DT   = CW'(DEADTIME);

  typedef enum logic [1:0] {IDLE, DEAD, ON} state_t;

  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic [1:0]     r_sel;
  logic [15:0]    r_active;
  logic [15:0]    r_pending;
  logic           r_pend_flag;
  logic [3:0]     r_nibble;
  logic           r_digit_off;
  logic           r_load_ack;
  logic           r_frame_done;

  state_t         w_state_nxt;
  logic [CW-1:0]  w_cnt_nxt;
  logic [1:0]     w_sel_nxt;
  logic           w_wrap;
  logic [15:0]    w_active_nxt;
  logic [15:0]    w_pending_nxt;
  logic           w_pend_flag_nxt;
  logic           w_ack_nxt;
  logic           w_off_nxt;
  logic [3:0]     w_nibble_nxt;

  // A digit is dark when it is not digit 0 and it, and every digit above it, is zero
  function automatic logic blank_digit(input logic lz, input logic [1:0] d,
                                       input logic [15:0] w);
    logic b;
    case (d)
      2'd1:    b = (w[15:4] == 12'd0);
      2'd2:    b = (w[15:8] == 8'd0);
      2'd3:    b = (w[15:12] == 4'd0);
      default: b = 1'b0;
    endcase
    return lz && b;
  endfunction

  // Scan FSM: slot counter, digit select and detection of the frame wrap
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sel_nxt   = r_sel;
    w_wrap      = 1'b0;
    if (!i_en) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_cnt_nxt   = '0;
          w_state_nxt = (DEADTIME == 0) ? ON : DEAD;
        end
        DEAD: begin
          w_cnt_nxt = r_cnt + 1'b1;
          if (w_cnt_nxt == DT) w_state_nxt = ON;
        end
        ON: begin
          if (r_cnt == LAST) begin
            w_cnt_nxt   = '0;
            w_sel_nxt   = r_sel + 2'd1;
            w_state_nxt = (DEADTIME == 0) ? ON : DEAD;
            w_wrap      = (r_sel == 2'd3);
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Double buffer: a load that lands on the wrap edge bypasses the pending register
  always_comb begin
    w_active_nxt    = r_active;
    w_pending_nxt   = r_pending;
    w_pend_flag_nxt = r_pend_flag;
    w_ack_nxt       = 1'b0;
    if (w_wrap && i_load) begin
      w_active_nxt    = i_value;
      w_pend_flag_nxt = 1'b0;
      w_ack_nxt       = 1'b1;
    end else begin
      if (r_pend_flag && (w_wrap || r_state == IDLE)) begin
        w_active_nxt    = r_pending;
        w_pend_flag_nxt = 1'b0;
        w_ack_nxt       = 1'b1;
      end
      if (i_load) begin
        w_pending_nxt   = i_value;
        w_pend_flag_nxt = 1'b1;
      end
    end
  end

  // Output values come from the next-state view, so the registered outputs match the new slot
  always_comb begin
    w_nibble_nxt = w_active_nxt[{w_sel_nxt, 2'b00} +: 4];
    w_off_nxt    = (w_state_nxt != ON) || blank_digit(i_blank_lz, w_sel_nxt, w_active_nxt);
  end

  // State and registered outputs; everything clears as soon as reset is asserted
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_sel        <= 2'd0;
      r_active     <= 16'd0;
      r_pending    <= 16'd0;
      r_pend_flag  <= 1'b0;
      r_nibble     <= 4'd0;
      r_digit_off  <= 1'b1;
      r_load_ack   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_sel        <= w_sel_nxt;
      r_active     <= w_active_nxt;
      r_pending    <= w_pending_nxt;
      r_pend_flag  <= w_pend_flag_nxt;
      r_nibble     <= w_nibble_nxt;
      r_digit_off  <= w_off_nxt;
      r_load_ack   <= w_ack_nxt;
      r_frame_done <= w_wrap;
    end
  end

  assign o_sel        = r_sel;
  assign o_nibble     = r_nibble;
  assign o_digit_off  = r_digit_off;
  assign o_load_ack   = r_load_ack;
  assign o_frame_done = r_frame_done;

endmodule
